// File: rtl/sd_xfer_sequencer_pkg.sv
// Shared state encodings, error codes and constants for the SD transfer sequencer.
// SD_SEQ_AUTO_CMD12_EN adds the auto-CMD12 states.
package sd_xfer_sequencer_pkg;

  // DONE and ERR share StFin; a separate flag tells them apart.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StIssue    = 3'd1,
    StWaitResp = 3'd2,
    StStartDma = 3'd3,
    StWaitXfer = 3'd4,
`ifdef SD_SEQ_AUTO_CMD12_EN
    StA12Issue = 3'd5,
    StA12Wait  = 3'd6,
`endif
    StFin      = 3'd7
  } seq_state_e;

  localparam logic [2:0] ErrNone       = 3'd0;
  localparam logic [2:0] ErrCmdTimeout = 3'd1;
  localparam logic [2:0] ErrDma        = 3'd2;
  localparam logic [2:0] ErrWdog       = 3'd3;
  localparam logic [2:0] ErrAbort      = 3'd4;
  localparam logic [2:0] ErrA12Timeout = 3'd5;

  localparam logic [5:0] Cmd12Index = 6'd12;

endpackage

// File: rtl/sd_xfer_sequencer_if.sv
// Handshake bundle between the sequencer and the register file / CMD / dma / DAT blocks.
// master is the sequencer's view, slave the surrounding blocks' view.
interface sd_xfer_sequencer_if;
  logic       cmd_wr;
  logic [5:0] cmd_index;
  logic       data_present;
  logic       multi_blk;
  logic       stop_req;
  logic       cmd_complete;
  logic       cmd_timeout;
  logic       dma_done;
  logic       dma_error;
  logic       dat_done;
  logic       new_cmd;
  logic [5:0] new_cmd_index;
  logic       dma_start;
  logic       seq_busy;
  logic       cmd_done_irq;
  logic       xfer_done_irq;
  logic       err_irq;
  logic [2:0] err_code;
  logic       cmd_rejected;

  modport master (
    input  cmd_wr, cmd_index, data_present, multi_blk, stop_req,
    input  cmd_complete, cmd_timeout, dma_done, dma_error, dat_done,
    output new_cmd, new_cmd_index, dma_start, seq_busy,
    output cmd_done_irq, xfer_done_irq, err_irq, err_code, cmd_rejected
  );

  modport slave (
    output cmd_wr, cmd_index, data_present, multi_blk, stop_req,
    output cmd_complete, cmd_timeout, dma_done, dma_error, dat_done,
    input  new_cmd, new_cmd_index, dma_start, seq_busy,
    input  cmd_done_irq, xfer_done_irq, err_irq, err_code, cmd_rejected
  );
endinterface

// File: rtl/sd_xfer_sequencer_seq_watchdog.sv
// Transfer watchdog: counts enabled cycles and flags the cycle the count reaches WDOG_MAX.
module seq_watchdog #(
  parameter int unsigned       WDOG_W   = 16,
  parameter logic [WDOG_W-1:0] WDOG_MAX = 16'hFFFF
) (
  input  logic CLK,
  input  logic rst_L,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [WDOG_W-1:0] count_q;

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Fires in the cycle whose increment would make the count equal WDOG_MAX.
  assign expire = enable && (count_q == WDOG_MAX - 1'b1);

endmodule

// File: rtl/sd_xfer_sequencer.sv
// SD transaction sequencer: command issue, data phase launch/wait, interrupts and error cause.
// Define SD_SEQ_AUTO_CMD12_EN to append an automatic CMD12 after multi-block transfers.
module sd_xfer_sequencer
  import sd_xfer_sequencer_pkg::*;
#(
  parameter int unsigned       WDOG_W   = 16,
  parameter logic [WDOG_W-1:0] WDOG_MAX = 16'hFFFF
) (
  input logic                 CLK,
  input logic                 rst_L,
  sd_xfer_sequencer_if.master bus
);

  seq_state_e state_q, state_d;
  logic       fin_err_q, fin_err_d;
  logic [2:0] err_code_q, err_code_d;
  logic [5:0] index_q, index_d;
  logic       dma_seen_q, dma_seen_d;
  logic       dat_seen_q, dat_seen_d;
  logic       cmd_done_q, cmd_done_d;
  logic       xfer_done_q, xfer_done_d;
  logic       rejected_q, rejected_d;
  logic       wd_clear, wd_enable, wd_expire;
  logic       xfer_both;
  logic       in_flight;

  seq_watchdog #(
    .WDOG_W  (WDOG_W),
    .WDOG_MAX(WDOG_MAX)
  ) u_wdog (
    .CLK   (CLK),
    .rst_L (rst_L),
    .clear (wd_clear),
    .enable(wd_enable),
    .expire(wd_expire)
  );

  assign in_flight = (state_q != StIdle) && (state_q != StFin);
  assign xfer_both = (dma_seen_q | bus.dma_done) & (dat_seen_q | bus.dat_done);

  always_comb begin
    state_d     = state_q;
    fin_err_d   = fin_err_q;
    err_code_d  = err_code_q;
    index_d     = index_q;
    dma_seen_d  = dma_seen_q;
    dat_seen_d  = dat_seen_q;
    cmd_done_d  = 1'b0;
    xfer_done_d = 1'b0;
    rejected_d  = bus.cmd_wr && (state_q != StIdle);
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_wr) begin
          state_d    = StIssue;
          index_d    = bus.cmd_index;
          err_code_d = ErrNone;
        end
      end
      StIssue: state_d = StWaitResp;
      StWaitResp: begin
        if (bus.cmd_timeout) begin
          state_d    = StFin;
          fin_err_d  = 1'b1;
          err_code_d = ErrCmdTimeout;
        end else if (bus.cmd_complete) begin
          cmd_done_d = 1'b1;
          fin_err_d  = 1'b0;
          state_d    = bus.data_present ? StStartDma : StFin;
        end
      end
      StStartDma: begin
        wd_clear   = 1'b1;
        dma_seen_d = 1'b0;
        dat_seen_d = 1'b0;
        state_d    = StWaitXfer;
      end
      StWaitXfer: begin
        wd_enable  = 1'b1;
        dma_seen_d = dma_seen_q | bus.dma_done;
        dat_seen_d = dat_seen_q | bus.dat_done;
        if (bus.dma_error) begin
          state_d    = StFin;
          fin_err_d  = 1'b1;
          err_code_d = ErrDma;
        end else if (xfer_both) begin
          xfer_done_d = 1'b1;
          fin_err_d   = 1'b0;
`ifdef SD_SEQ_AUTO_CMD12_EN
          state_d     = bus.multi_blk ? StA12Issue : StFin;
`else
          state_d     = StFin;
`endif
        end else if (wd_expire) begin
          state_d    = StFin;
          fin_err_d  = 1'b1;
          err_code_d = ErrWdog;
        end
      end
`ifdef SD_SEQ_AUTO_CMD12_EN
      StA12Issue: state_d = StA12Wait;
      StA12Wait: begin
        if (bus.cmd_timeout) begin
          state_d    = StFin;
          fin_err_d  = 1'b1;
          err_code_d = ErrA12Timeout;
        end else if (bus.cmd_complete) begin
          state_d   = StFin;
          fin_err_d = 1'b0;
        end
      end
`endif
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides every other event, including any pulse decided above.
    if (bus.stop_req && in_flight) begin
      state_d     = StFin;
      fin_err_d   = 1'b1;
      err_code_d  = ErrAbort;
      cmd_done_d  = 1'b0;
      xfer_done_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= StIdle;
      fin_err_q   <= 1'b0;
      err_code_q  <= ErrNone;
      index_q     <= '0;
      dma_seen_q  <= 1'b0;
      dat_seen_q  <= 1'b0;
      cmd_done_q  <= 1'b0;
      xfer_done_q <= 1'b0;
      rejected_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fin_err_q   <= fin_err_d;
      err_code_q  <= err_code_d;
      index_q     <= index_d;
      dma_seen_q  <= dma_seen_d;
      dat_seen_q  <= dat_seen_d;
      cmd_done_q  <= cmd_done_d;
      xfer_done_q <= xfer_done_d;
      rejected_q  <= rejected_d;
    end
  end

`ifdef SD_SEQ_AUTO_CMD12_EN
  assign bus.new_cmd       = (state_q == StIssue) || (state_q == StA12Issue);
  assign bus.new_cmd_index = (state_q == StA12Issue) ? Cmd12Index : index_q;
`else
  assign bus.new_cmd       = (state_q == StIssue);
  assign bus.new_cmd_index = index_q;
`endif
  assign bus.dma_start     = (state_q == StStartDma);
  assign bus.seq_busy      = (state_q != StIdle);
  assign bus.err_irq       = (state_q == StFin) && fin_err_q;
  assign bus.cmd_done_irq  = cmd_done_q;
  assign bus.xfer_done_irq = xfer_done_q;
  assign bus.err_code      = err_code_q;
  assign bus.cmd_rejected  = rejected_q;

endmodule

// File: tb/tb_sd_xfer_sequencer.sv
// Randomised self-checking bench for sd_xfer_sequencer; expectations come from an event-time
// model of each transaction (which event ends it, and when).
module tb_sd_xfer_sequencer;

  localparam int WdogMaxTb = 100;
  localparam int Big       = 1 << 30;

  logic CLK   = 1'b0;
  logic rst_L = 1'b0;
  always #5 CLK = ~CLK;

  sd_xfer_sequencer_if bus ();

  sd_xfer_sequencer #(
    .WDOG_W  (16),
    .WDOG_MAX(16'd100)
  ) dut (
    .CLK  (CLK),
    .rst_L(rst_L),
    .bus  (bus)
  );

  typedef struct {
    int idx;  bit dp;  bit mb;  int resp; bit tmo;
    int dat;  int dma; int err; int stop; int rej; int a12;
  } txn_t;

  typedef struct packed {
    logic [3:0]  n_new_cmd;
    logic [5:0]  new_idx;
    logic [3:0]  n_cmd_done;
    logic [3:0]  n_dma_start;
    logic [3:0]  n_xfer;
    logic [15:0] xfer_cyc;
    logic [3:0]  n_err;
    logic [15:0] err_cyc;
    logic [2:0]  err_code;
    logic [15:0] end_cyc;
    logic [3:0]  n_rej;
    logic [3:0]  n_overlap;
    logic [5:0]  final_idx;
  } res_t;

  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   t0         = 0;
  int   rel;
  bit   mon_on     = 1'b0;
  res_t obs;

  always @(posedge CLK) cyc <= cyc + 1;
  assign rel = cyc - t0;

  // Collects pulse counts and cycle stamps relative to the cmd_wr cycle.
  always @(negedge CLK) begin
    if (!mon_on) begin
      obs <= '0;
    end else begin
      if (bus.new_cmd) begin
        obs.n_new_cmd <= obs.n_new_cmd + 4'd1;
        obs.new_idx   <= bus.new_cmd_index;
      end
      if (bus.cmd_done_irq) obs.n_cmd_done <= obs.n_cmd_done + 4'd1;
      if (bus.dma_start) obs.n_dma_start <= obs.n_dma_start + 4'd1;
      if (bus.xfer_done_irq) begin
        obs.n_xfer   <= obs.n_xfer + 4'd1;
        obs.xfer_cyc <= 16'(rel);
      end
      if (bus.err_irq) begin
        obs.n_err   <= obs.n_err + 4'd1;
        obs.err_cyc <= 16'(rel);
      end
      if (bus.cmd_rejected) obs.n_rej <= obs.n_rej + 4'd1;
      if (bus.new_cmd && bus.dma_start) obs.n_overlap <= obs.n_overlap + 4'd1;
      if (!bus.seq_busy && rel >= 1 && obs.end_cyc == 16'd0) obs.end_cyc <= 16'(rel);
      obs.err_code  <= bus.err_code;
      obs.final_idx <= bus.new_cmd_index;
    end
  end

  function automatic txn_t mk(input int idx, input bit dp, input int resp);
    txn_t t;
    t.idx = idx; t.dp = dp; t.mb = 1'b0; t.resp = resp; t.tmo = 1'b0;
    t.dat = -1; t.dma = -1; t.err = -1; t.stop = -1; t.rej = -1; t.a12 = -1;
    return t;
  endfunction

  // Decide which event ends the transaction from the event times alone.
  function automatic res_t predict(input txn_t t);
    res_t e;
    int tr, w, x, tc, te, code;
    bit is_err, data_ph, resp_ok;
    e = '0;
    e.n_new_cmd = 4'd1;
    e.new_idx   = 6'(t.idx);
    e.final_idx = 6'(t.idx);
    tr = 2 + t.resp;
    data_ph = 1'b0;
    code = 0;
    if (t.tmo) begin
      x = tr; is_err = 1'b1; code = 1;
    end else if (!t.dp) begin
      x = tr; is_err = 1'b0;
    end else begin
      data_ph = 1'b1;
      w  = tr + 2;
      x  = w + WdogMaxTb - 1; is_err = 1'b1; code = 3;
      tc = (t.dat >= 0 && t.dma >= 0) ? w + ((t.dat > t.dma) ? t.dat : t.dma) : Big;
      if (tc <= x) begin x = tc; is_err = 1'b0; code = 0; end
      te = (t.err >= 0) ? w + t.err : Big;
      if (te <= x) begin x = te; is_err = 1'b1; code = 2; end
    end
    resp_ok = !t.tmo;
    if (t.stop >= 1 && t.stop <= x) begin
      if (t.stop <= tr) resp_ok = 1'b0;
      x = t.stop; is_err = 1'b1; code = 4;
    end
    if (resp_ok) e.n_cmd_done = 4'd1;
    if (resp_ok && t.dp) e.n_dma_start = 4'd1;
    if (is_err) begin
      e.n_err = 4'd1; e.err_cyc = 16'(x + 1);
    end else if (data_ph) begin
      e.n_xfer = 4'd1; e.xfer_cyc = 16'(x + 1);
    end
    e.err_code = 3'(code);
    e.end_cyc  = 16'(x + 2);
    if (t.rej >= 1 && t.rej <= x + 1) e.n_rej = 4'd1;
    return e;
  endfunction

  task automatic clear_inputs();
    bus.cmd_wr = 1'b0; bus.cmd_index = '0; bus.data_present = 1'b0; bus.multi_blk = 1'b0;
    bus.stop_req = 1'b0; bus.cmd_complete = 1'b0; bus.cmd_timeout = 1'b0;
    bus.dma_done = 1'b0; bus.dma_error = 1'b0; bus.dat_done = 1'b0;
  endtask

  // Plays the event schedule for a fixed window; called at posedge+1.
  task automatic run_txn(input txn_t t, input int lim, output res_t o);
    int tr, w;
    tr = 2 + t.resp;
    w  = tr + 2;
    t0 = cyc;
    mon_on = 1'b1;
    for (int r = 0; r < lim; r++) begin
      bus.cmd_wr       = (r == 0) || (r == t.rej);
      bus.cmd_index    = (r == t.rej) ? ~6'(t.idx) : 6'(t.idx);
      bus.data_present = t.dp;
      bus.multi_blk    = t.mb;
      bus.cmd_complete = (!t.tmo && r == tr) || (r == t.a12);
      bus.cmd_timeout  = t.tmo && r == tr;
      bus.dat_done     = !t.tmo && t.dp && t.dat >= 0 && r == w + t.dat;
      bus.dma_done     = !t.tmo && t.dp && t.dma >= 0 && r == w + t.dma;
      bus.dma_error    = !t.tmo && t.dp && t.err >= 0 && r == w + t.err;
      bus.stop_req     = (r == t.stop);
      @(posedge CLK); #1;
    end
    clear_inputs();
    o = obs;
    mon_on = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_L = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if ({bus.new_cmd, bus.dma_start, bus.seq_busy, bus.cmd_done_irq, bus.xfer_done_irq,
         bus.err_irq, bus.cmd_rejected, bus.err_code, bus.new_cmd_index} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_hold: outputs %b seq_busy %b err_code %0d idx %0d, want all 0",
               {bus.new_cmd, bus.dma_start, bus.cmd_done_irq, bus.xfer_done_irq, bus.err_irq,
                bus.cmd_rejected}, bus.seq_busy, bus.err_code, bus.new_cmd_index);
    end
    rst_L = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (bus.seq_busy !== 1'b0 || bus.err_code !== 3'd0 || bus.new_cmd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: seq_busy %b err_code %0d new_cmd %b, want 0 0 0",
               bus.seq_busy, bus.err_code, bus.new_cmd);
    end
  endtask

  task automatic test_non_data();
    txn_t t; res_t o, e;
    t = mk(8, 1'b0, 3);
    e = predict(t);
    run_txn(t, 12, o);
    vectors++;
    if (o !== e) begin
      miscompares++; $display("FAIL non_data: got %h want %h", o, e);
    end
    vectors++;
    if (o.n_new_cmd !== 4'd1 || o.new_idx !== 6'd8) begin
      miscompares++;
      $display("FAIL non_data_issue: new_cmd x%0d idx %0d, want x1 idx 8", o.n_new_cmd, o.new_idx);
    end
    vectors++;
    if (o.end_cyc !== 16'd7 || o.n_dma_start !== 4'd0 || o.n_cmd_done !== 4'd1) begin
      miscompares++;
      $display("FAIL non_data_end: busy low at %0d dma_start x%0d cmd_done x%0d, want 7 x0 x1",
               o.end_cyc, o.n_dma_start, o.n_cmd_done);
    end
  endtask

  task automatic test_data_read();
    txn_t t; res_t o, e;
    t = mk(17, 1'b1, 2);
    t.mb = 1'b0;
    t.dat = 8; t.dma = 18;
    e = predict(t);
    run_txn(t, int'(e.end_cyc) + 3, o);
    vectors++;
    if (o !== e) begin
      miscompares++; $display("FAIL data_read: got %h want %h", o, e);
    end
    vectors++;
    if (o.xfer_cyc !== 16'd25 || o.err_code !== 3'd0 || o.n_dma_start !== 4'd1) begin
      miscompares++;
      $display("FAIL data_read_xfer: xfer_done at %0d err_code %0d dma_start x%0d, want 25 0 x1",
               o.xfer_cyc, o.err_code, o.n_dma_start);
    end
  endtask

  task automatic test_simul_finish();
    txn_t t; res_t o, e;
    t = mk(18, 1'b1, 1);
    t.dat = $urandom_range(0, 30);
    t.dma = t.dat;
    e = predict(t);
    run_txn(t, int'(e.end_cyc) + 3, o);
    vectors++;
    if (o !== e || o.n_xfer !== 4'd1) begin
      miscompares++; $display("FAIL simul_finish: got %h want %h", o, e);
    end
  endtask

  task automatic test_err_vs_done();
    txn_t t; res_t o, e;
    t = mk(24, 1'b1, 0);
    t.dat = 2; t.dma = 6; t.err = 6;
    e = predict(t);
    run_txn(t, int'(e.end_cyc) + 3, o);
    vectors++;
    if (o !== e) begin
      miscompares++; $display("FAIL err_vs_done: got %h want %h", o, e);
    end
    vectors++;
    if (o.err_code !== 3'd2 || o.n_xfer !== 4'd0 || o.n_err !== 4'd1) begin
      miscompares++;
      $display("FAIL err_vs_done_code: err_code %0d xfer x%0d err_irq x%0d, want 2 x0 x1",
               o.err_code, o.n_xfer, o.n_err);
    end
  endtask

  task automatic test_watchdog();
    txn_t t; res_t o, e;
    t = mk(3, 1'b1, 1);
    e = predict(t);
    run_txn(t, int'(e.end_cyc) + 3, o);
    vectors++;
    if (o !== e) begin
      miscompares++; $display("FAIL watchdog: got %h want %h", o, e);
    end
    // dma_start lands at rel 4; ERR follows 100 WAIT_XFER cycles later.
    vectors++;
    if (o.err_code !== 3'd3 || o.err_cyc !== 16'd105) begin
      miscompares++;
      $display("FAIL watchdog_time: err_code %0d err_irq at %0d, want 3 at 105",
               o.err_code, o.err_cyc);
    end
  endtask

  task automatic test_abort();
    txn_t t; res_t o, e;
    t = mk(9, 1'b1, 6);
    t.dat = 1; t.dma = 1; t.stop = 5;
    e = predict(t);
    run_txn(t, int'(e.end_cyc) + 3, o);
    vectors++;
    if (o.err_code !== 3'd4 || o.err_cyc !== 16'd6 || o.n_cmd_done !== 4'd0) begin
      miscompares++;
      $display("FAIL abort_resp: err_code %0d err_irq at %0d cmd_done x%0d, want 4 at 6 x0",
               o.err_code, o.err_cyc, o.n_cmd_done);
    end
    t = mk(10, 1'b1, 0);
    t.dat = 30; t.dma = 30; t.stop = 10;
    e = predict(t);
    run_txn(t, int'(e.end_cyc) + 3, o);
    vectors++;
    if (o !== e) begin
      miscompares++; $display("FAIL abort_xfer: got %h want %h", o, e);
    end
  endtask

  task automatic test_reject();
    txn_t t; res_t o, e;
    t = mk(21, 1'b0, 4);
    t.rej = 2;
    e = predict(t);
    run_txn(t, int'(e.end_cyc) + 3, o);
    vectors++;
    if (o.n_rej !== 4'd1 || o.final_idx !== 6'd21 || o.n_new_cmd !== 4'd1) begin
      miscompares++;
      $display("FAIL reject: rejected x%0d idx %0d new_cmd x%0d, want x1 21 x1",
               o.n_rej, o.final_idx, o.n_new_cmd);
    end
  endtask

  task automatic test_async_reset();
    bus.cmd_index = 6'd17;
    bus.cmd_wr    = 1'b1;
    @(posedge CLK); #1;
    bus.cmd_wr = 1'b0;
    @(posedge CLK); #1;
    vectors++;
    if (bus.seq_busy !== 1'b1 || bus.new_cmd_index !== 6'd17) begin
      miscompares++;
      $display("FAIL async_pre: seq_busy %b idx %0d, want 1 17", bus.seq_busy, bus.new_cmd_index);
    end
    #2 rst_L = 1'b0;
    #1;
    vectors++;
    if (bus.seq_busy !== 1'b0 || bus.new_cmd_index !== 6'd0) begin
      miscompares++;
      $display("FAIL async_reset: seq_busy %b idx %0d, want 0 0", bus.seq_busy, bus.new_cmd_index);
    end
    @(posedge CLK); #1;
    rst_L = 1'b1;
    @(posedge CLK); #1;
  endtask

`ifdef SD_SEQ_AUTO_CMD12_EN
  task automatic test_auto_cmd12();
    txn_t t; res_t o;
    t = mk(18, 1'b1, 1);
    t.mb = 1'b1; t.dat = 2; t.dma = 4; t.a12 = 11;
    run_txn(t, 16, o);
    vectors++;
    if (o.n_new_cmd !== 4'd2 || o.new_idx !== 6'd12 || o.xfer_cyc !== 16'd10 ||
        o.end_cyc !== 16'd13 || o.n_cmd_done !== 4'd1) begin
      miscompares++;
      $display("FAIL auto_cmd12: new_cmd x%0d last idx %0d xfer %0d end %0d cmd_done x%0d",
               o.n_new_cmd, o.new_idx, o.xfer_cyc, o.end_cyc, o.n_cmd_done);
    end
  endtask
`endif

  task automatic test_random();
    txn_t t; res_t o, e;
    for (int n = 0; n < 40; n++) begin
      t = mk(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
`ifndef SD_SEQ_AUTO_CMD12_EN
      t.mb = 1'($urandom_range(0, 1));
`endif
      t.tmo = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) != 0) begin
        t.dat = int'($urandom_range(0, 25));
        t.dma = int'($urandom_range(0, 25));
      end
      if ($urandom_range(0, 3) == 0) t.err = int'($urandom_range(0, 25));
      if ($urandom_range(0, 4) == 0) t.stop = int'($urandom_range(2, 40));
      if ($urandom_range(0, 3) == 0) t.rej = int'($urandom_range(1, 3));
      e = predict(t);
      run_txn(t, int'(e.end_cyc) + 3, o);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random[%0d] idx=%0d dp=%0d resp=%0d tmo=%0d dat=%0d dma=%0d err=%0d stop=%0d rej=%0d: got %h want %h",
                 n, t.idx, t.dp, t.resp, t.tmo, t.dat, t.dma, t.err, t.stop, t.rej, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_non_data();
    test_data_read();
    test_simul_finish();
    test_err_vs_done();
    test_watchdog();
    test_abort();
    test_reject();
    test_async_reset();
`ifdef SD_SEQ_AUTO_CMD12_EN
    test_auto_cmd12();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/sd_xfer_sequencer.md
Name: sd_xfer_sequencer

Overview:
- Sequences one SD transaction end to end:
  - issues the command to the CMD block and waits for its response;
  - for data commands, launches the ADMA engine and DAT block, then waits for both to finish;
  - raises completion and error interrupt pulses toward the register file.
- Sits between the Command/Transfer Mode registers and the CMD, dma and DAT blocks inside sd_host.
- Replaces the raw CR[15] new_cmd drive with a single decision point for transfer lifecycle.

Parameters:
- WDOG_W, 16, width of the transfer watchdog counter.
- WDOG_MAX, 16'hFFFF, cycles allowed in WAIT_XFER before a watchdog error.

Ports:
- CLK  in  1  host clock.
- rst_L  in  1  asynchronous active-low reset.
- cmd_wr  in  1  pulse: host wrote the Command Register.
- cmd_index  in  6  CR[13:8].
- data_present  in  1  CR[5]: command carries data.
- multi_blk  in  1  TMR[5].
- stop_req  in  1  level: core STOP (abort).
- cmd_complete  in  1  pulse from CMD.
- cmd_timeout  in  1  pulse from CMD.
- dma_done  in  1  pulse: ADMA finished its descriptor list.
- dma_error  in  1  pulse: ADMA error.
- dat_done  in  1  pulse: DAT transfer complete.
- new_cmd  out  1  1-cycle pulse to CMD.
- new_cmd_index  out  6  index presented with new_cmd.
- dma_start  out  1  1-cycle pulse to dma.
- seq_busy  out  1  high in every state except IDLE.
- cmd_done_irq  out  1  pulse: response received.
- xfer_done_irq  out  1  pulse: data phase finished.
- err_irq  out  1  pulse on entry to ERR.
- err_code  out  3  latched cause: 0 none, 1 cmd timeout, 2 dma error, 3 watchdog, 4 abort, 5 auto-CMD12 timeout.
- cmd_rejected  out  1  pulse: cmd_wr arrived while busy.

Behaviour:
- Reset (rst_L=0, asynchronous):
  - state returns to IDLE.
  - All pulse outputs, seq_busy, err_code and new_cmd_index go to 0.
  - The watchdog counter and the done flags clear.
- IDLE:
  - cmd_wr leads to ISSUE. cmd_index is latched into new_cmd_index on that edge.
  - err_code clears to 0 on that edge.
- ISSUE:
  - new_cmd=1 for exactly one cycle, then go to WAIT_RESP.
- WAIT_RESP:
  - cmd_complete: pulse cmd_done_irq. If data_present=1, go to START_DMA; otherwise go to DONE.
  - cmd_timeout: err_code=1, go to ERR.
  - If both pulses arrive in the same cycle, cmd_timeout wins.
- START_DMA:
  - dma_start=1 for one cycle.
  - Clear the flags dma_seen and dat_seen and the watchdog.
  - Go to WAIT_XFER.
- WAIT_XFER:
  - dma_done sets dma_seen; dat_done sets dat_seen. Either pulse may arrive first or in the same cycle.
  - When both flags are set (including the cycle they complete), pulse xfer_done_irq and go to DONE. With AUTO_CMD12_EN defined and multi_blk=1, go to A12_ISSUE instead.
  - dma_error: err_code=2, go to ERR. This has priority over done pulses in the same cycle.
  - The watchdog increments every cycle. On reaching WDOG_MAX: err_code=3, go to ERR.
- DONE:
  - One cycle, then return to IDLE. seq_busy drops the cycle after DONE.
- ERR:
  - err_irq=1 for one cycle; err_code holds until the next accepted cmd_wr.
  - Then go to IDLE.
- stop_req=1 in any state other than IDLE/DONE/ERR:
  - err_code=4, go to ERR next cycle.
  - stop_req has highest priority of all events.
- cmd_wr when not in IDLE:
  - Ignored; cmd_rejected pulses.
  - Latched fields are unchanged.
- new_cmd and dma_start never assert in the same cycle.

Optional Feature:
- Macro: SD_SEQ_AUTO_CMD12_EN.
- Defined:
  - States A12_ISSUE and A12_WAIT exist.
  - A12_ISSUE pulses new_cmd with new_cmd_index=6'd12.
  - A12_WAIT: cmd_complete goes to DONE without pulsing cmd_done_irq; cmd_timeout sets err_code=5 and goes to ERR.
  - xfer_done_irq is still pulsed on leaving WAIT_XFER.
- Undefined:
  - States are absent; multi-block transfers go straight to DONE.
  - Code 5 never occurs.

Decomposition:
- Shared defines file holds:
  - state encodings (3-bit: IDLE, ISSUE, WAIT_RESP, START_DMA, WAIT_XFER, A12_ISSUE, A12_WAIT, DONE/ERR packed);
  - err_code constants;
  - the CMD12 index constant.
- One sub-module: seq_watchdog, a WDOG_W-bit counter with clear, enable and expire outputs.

Test Plan:
- Non-data command: cmd_wr with cmd_index=8, data_present=0; cmd_complete 5 cycles later.
  - new_cmd pulses once with index 8.
  - cmd_done_irq pulses.
  - seq_busy falls 2 cycles after cmd_complete; no dma_start.
- Data read: data_present=1; after cmd_complete, dat_done at +10 cycles and dma_done at +20 cycles.
  - One dma_start.
  - xfer_done_irq exactly on the dma_done cycle+1 transition, err_code=0.
- Simultaneous finish: dma_done and dat_done in the same cycle.
  - Single xfer_done_irq.
- Simultaneous done and error: dma_error and dma_done in the same cycle.
  - err_irq, err_code=2, no xfer_done_irq.
- Watchdog expiry: WDOG_MAX=100, no done pulses.
  - err_code=3 after 100 cycles in WAIT_XFER.
- Abort and reject:
  - stop_req mid WAIT_RESP gives err_code=4.
  - cmd_wr during busy gives cmd_rejected and unchanged new_cmd_index.
  - With SD_SEQ_AUTO_CMD12_EN defined and multi_blk=1, a second new_cmd with index 12 follows the data phase.
